// File: rtl/kf_pkg.sv
// rtl/kf_pkg.sv - shared widths, z-matrix field offsets and sequencer state encoding
`timescale 1ns/1ps
package kf_pkg;

    localparam int W = 16;

    // Packed z word is {z11r,z11i,z12r,z12i,z21r,z21i,z22r,z22i}, z11r in the MSBs
    localparam int Z11R_LSB = 7 * W;
    localparam int Z11I_LSB = 6 * W;
    localparam int Z12R_LSB = 5 * W;
    localparam int Z12I_LSB = 4 * W;
    localparam int Z21R_LSB = 3 * W;
    localparam int Z21I_LSB = 2 * W;
    localparam int Z22R_LSB = 1 * W;
    localparam int Z22I_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_FIN     = 3'd4
    } kf_state_t;

endpackage

// File: rtl/kf_zbank.sv
// rtl/kf_zbank.sv - z-matrix sample bank with write rejection and wr_err pulse
`timescale 1ns/1ps
module kf_zbank #(
    parameter int W     = kf_pkg::W,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [8*W-1:0]    wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [8*W-1:0]    rd_data,
    output logic              wr_err
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [8*W-1:0] mem [DEPTH];
    logic           wr_addr_ok;
    logic           rd_addr_ok;

    assign wr_addr_ok = {1'b0, wr_addr} < DEPTH_V;
    assign rd_addr_ok = {1'b0, rd_addr} < DEPTH_V;
    assign rd_data    = rd_addr_ok ? mem[rd_addr] : '0;

    // Contents survive reset so a reload is not needed after a mid-run abort
    always_ff @(posedge clk) begin
        if (wr_en && !busy && wr_addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (busy || !wr_addr_ok);
        end
    end

endmodule

// File: rtl/kf_meas_sequencer.sv
// rtl/kf_meas_sequencer.sv - presents stored z samples to the filter and captures h11 per iteration
`timescale 1ns/1ps
module kf_meas_sequencer #(
    parameter int W       = kf_pkg::W,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk_300,
    input  logic                rst_n_btn,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [8*W-1:0]      wr_data,
    input  logic                start,
    input  logic [AW:0]         num_iter,
    input  logic                valid_all,
    input  logic signed [W-1:0] h11r_in,
    input  logic signed [W-1:0] h11i_in,
    output logic signed [W-1:0] z11r_out,
    output logic signed [W-1:0] z11i_out,
    output logic signed [W-1:0] z12r_out,
    output logic signed [W-1:0] z12i_out,
    output logic signed [W-1:0] z21r_out,
    output logic signed [W-1:0] z21i_out,
    output logic signed [W-1:0] z22r_out,
    output logic signed [W-1:0] z22i_out,
    output logic                busy,
    output logic                done,
    output logic                cap_valid,
    output logic [AW-1:0]       cap_idx,
    output logic signed [W-1:0] cap_h11r,
    output logic signed [W-1:0] cap_h11i,
    output logic                timeout,
    output logic                wr_err
);
    import kf_pkg::*;

    localparam int              WDW      = $clog2(TIMEOUT);
    localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT - 1);
    localparam logic [AW:0]     DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_MAX = AW'(DEPTH - 1);

    kf_state_t       state;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   n_last;
    logic [WDW-1:0]  wdog;
    logic [8*W-1:0]  z_q;
    logic [8*W-1:0]  rd_data;
    logic [AW-1:0]   rd_addr;
    logic            wd_hit;

    // Read port looks ahead: sample 0 while idle, otherwise the next sample to present
    assign rd_addr = (state == ST_IDLE) ? '0 : idx + AW'(1);
    assign wd_hit  = (wdog == WD_MAX);

    kf_zbank #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_zbank (
        .clk     (clk_300),
        .rst_n   (rst_n_btn),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_err  (wr_err)
    );

    always_ff @(posedge clk_300 or negedge rst_n_btn) begin
        if (!rst_n_btn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            n_last    <= '0;
            wdog      <= '0;
            z_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            cap_h11r  <= '0;
            cap_h11i  <= '0;
            timeout   <= 1'b0;
        end else begin
            done      <= 1'b0;
            cap_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (start) begin
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        idx     <= '0;
                        n_last  <= (num_iter > DEPTH_V) ? LAST_MAX : num_iter[AW-1:0] - AW'(1);
                        if (num_iter == '0) begin
                            state <= ST_FIN;
                        end else begin
                            z_q   <= rd_data;
                            state <= ST_ARM;
                        end
                    end
                end
                // A level left high from the previous iteration must not count as completion
                ST_ARM: begin
                    if (!valid_all) begin
                        wdog  <= '0;
                        state <= ST_PRESENT;
                    end else if (wd_hit) begin
                        wdog    <= '0;
                        timeout <= 1'b1;
                        state   <= ST_FIN;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                ST_PRESENT: begin
                    if (valid_all) begin
                        cap_h11r  <= h11r_in;
                        cap_h11i  <= h11i_in;
                        cap_idx   <= idx;
                        cap_valid <= 1'b1;
                        wdog      <= '0;
                        state     <= ST_DRAIN;
                    end else if (wd_hit) begin
                        wdog    <= '0;
                        timeout <= 1'b1;
                        state   <= ST_FIN;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                // z only moves once valid_all has fallen, so the filter never sees it change mid-iteration
                ST_DRAIN: begin
                    if (!valid_all) begin
                        wdog <= '0;
                        if (idx == n_last) begin
                            state <= ST_FIN;
                        end else begin
                            idx   <= idx + AW'(1);
                            z_q   <= rd_data;
                            state <= ST_PRESENT;
                        end
                    end else if (wd_hit) begin
                        wdog    <= '0;
                        timeout <= 1'b1;
                        state   <= ST_FIN;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                ST_FIN: begin
                    wdog  <= '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign z11r_out = z_q[Z11R_LSB +: W];
    assign z11i_out = z_q[Z11I_LSB +: W];
    assign z12r_out = z_q[Z12R_LSB +: W];
    assign z12i_out = z_q[Z12I_LSB +: W];
    assign z21r_out = z_q[Z21R_LSB +: W];
    assign z21i_out = z_q[Z21I_LSB +: W];
    assign z22r_out = z_q[Z22R_LSB +: W];
    assign z22i_out = z_q[Z22I_LSB +: W];

endmodule

// File: tb/tb_kf_meas_sequencer.sv
// tb/tb_kf_meas_sequencer.sv - self-checking bench for kf_meas_sequencer with a stub filter
`timescale 1ns/1ps
module tb_kf_meas_sequencer;

    localparam int W       = 16;
    localparam int DEPTH   = 12;
    localparam int AW      = 4;
    localparam int TIMEOUT = 64;

    logic             clk_300;
    logic             rst_n_btn;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [8*W-1:0]   wr_data;
    logic             start;
    logic [AW:0]      num_iter;
    logic             valid_all;
    logic [W-1:0]     h11r_in, h11i_in;
    logic [W-1:0]     z11r_out, z11i_out, z12r_out, z12i_out;
    logic [W-1:0]     z21r_out, z21i_out, z22r_out, z22i_out;
    logic             busy, done, cap_valid, timeout, wr_err;
    logic [AW-1:0]    cap_idx;
    logic [W-1:0]     cap_h11r, cap_h11i;

    kf_meas_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_300   (clk_300),
        .rst_n_btn (rst_n_btn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .num_iter  (num_iter),
        .valid_all (valid_all),
        .h11r_in   (h11r_in),
        .h11i_in   (h11i_in),
        .z11r_out  (z11r_out),
        .z11i_out  (z11i_out),
        .z12r_out  (z12r_out),
        .z12i_out  (z12i_out),
        .z21r_out  (z21r_out),
        .z21i_out  (z21i_out),
        .z22r_out  (z22r_out),
        .z22i_out  (z22i_out),
        .busy      (busy),
        .done      (done),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx),
        .cap_h11r  (cap_h11r),
        .cap_h11i  (cap_h11i),
        .timeout   (timeout),
        .wr_err    (wr_err)
    );

    initial clk_300 = 1'b0;
    always #5 clk_300 = ~clk_300;

    typedef struct {
        int          idx;
        logic [W-1:0] r;
        logic [W-1:0] i;
    } cap_t;

    int             vectors = 0;
    int             miscompares = 0;
    logic [8*W-1:0] ref_mem [DEPTH];
    cap_t           exp_q [$];
    int             cap_cnt;
    int             done_cnt;
    bit             in_run;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [8*W-1:0] zcat();
        return {z11r_out, z11i_out, z12r_out, z12i_out, z21r_out, z21i_out, z22r_out, z22i_out};
    endfunction

    // One clock; outputs sampled 1ns after the edge, captures matched against the expected queue
    task automatic step();
        cap_t e;
        @(posedge clk_300);
        #1;
        if (cap_valid) begin
            if (exp_q.size() == 0) begin
                chk("cap_unexpected", 128'(cap_idx), 128'(999));
            end else begin
                e = exp_q.pop_front();
                chk("cap_idx", 128'(cap_idx), 128'(e.idx));
                chk("cap_h11r", 128'(cap_h11r), 128'(e.r));
                chk("cap_h11i", 128'(cap_h11i), 128'(e.i));
            end
            cap_cnt++;
        end
        if (done) done_cnt++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_z"}, 128'(zcat()), 128'(0));
        chk({tag, "_ctl"}, 128'({busy, done, cap_valid, timeout, wr_err}), 128'(0));
        chk({tag, "_cap"}, 128'({cap_idx, cap_h11r, cap_h11i}), 128'(0));
    endtask

    task automatic wr(input int addr, input logic [8*W-1:0] data);
        bit rej;
        rej     = in_run || (addr >= DEPTH);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = data;
        step();
        wr_en   = 1'b0;
        chk("wr_err", 128'(wr_err), 128'(rej));
        if (!rej) ref_mem[addr] = data;
    endtask

    // Stub filter iteration: low gap, then valid_all high for 3 cycles with a fixed estimate
    task automatic pulse(input int k, input logic [W-1:0] r, input logic [W-1:0] i, input int gap);
        valid_all = 1'b0;
        repeat (gap) step();
        h11r_in   = r;
        h11i_in   = i;
        valid_all = 1'b1;
        exp_q.push_back('{k, r, i});
        for (int c = 0; c < 3; c++) begin
            step();
            chk("z_during_valid", 128'(zcat()), 128'(ref_mem[k]));
        end
        valid_all = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done_cnt == 0 && cycles < budget) begin
            step();
            cycles++;
        end
        chk("done_seen", 128'(done_cnt > 0), 128'(1));
    endtask

    task automatic start_run(input int num, input bit stale);
        cap_cnt   = 0;
        done_cnt  = 0;
        exp_q.delete();
        in_run    = 1'b1;
        valid_all = stale;
        num_iter  = num[AW:0];
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("busy_on_start", 128'(busy), 128'(1));
        chk("timeout_cleared", 128'(timeout), 128'(0));
        if (stale) repeat (3) step();
    endtask

    task automatic finish_run(input int n);
        int cyc;
        valid_all = 1'b0;
        wait_done(20, cyc);
        step();
        chk("cap_count", 128'(cap_cnt), 128'(n));
        chk("done_once", 128'(done_cnt), 128'(1));
        chk("busy_idle", 128'(busy), 128'(0));
        in_run = 1'b0;
    endtask

    task automatic run_full(input int num, input bit stale, input int wr_at);
        int n;
        n = (num > DEPTH) ? DEPTH : num;
        start_run(num, stale);
        for (int k = 0; k < n; k++) begin
            if (k == wr_at) begin
                start = 1'b1;
                wr(0, {$urandom, $urandom, $urandom, $urandom});
                start = 1'b0;
            end
            pulse(k, W'($urandom), W'($urandom), int'($urandom_range(1, 4)));
        end
        finish_run(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n_btn = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        num_iter  = '0;
        valid_all = 1'b0;
        h11r_in   = '0;
        h11i_in   = '0;
        in_run    = 1'b0;
        cap_cnt   = 0;
        done_cnt  = 0;

        // Reset state, then an empty run
        repeat (20) @(posedge clk_300);
        #1;
        chk_reset_outputs("reset");
        rst_n_btn = 1'b1;
        step();
        for (int a = 0; a < DEPTH; a++) wr(a, {$urandom, $urandom, $urandom, $urandom});
        cap_cnt  = 0;
        done_cnt = 0;
        num_iter = '0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("n0_done_early", 128'(done), 128'(0));
        step();
        chk("n0_done", 128'(done), 128'(1));
        chk("n0_busy", 128'(busy), 128'(0));
        chk("n0_no_cap", 128'(cap_cnt), 128'(0));

        // Directed two-sample run
        wr(0, {16'd26214, 16'hF333, 96'd0});
        wr(1, 128'd0);
        start_run(2, 1'b0);
        chk("z11r_first", 128'(z11r_out), 128'(26214));
        chk("z11i_first", 128'(z11i_out), 128'(16'hF333));
        pulse(0, 16'd13107, 16'd0, 2);
        pulse(1, 16'd6553, 16'd0, 2);
        chk("z11r_second", 128'(z11r_out), 128'(0));
        finish_run(2);

        // Stale valid level at start
        run_full(3, 1'b1, -1);

        // Watchdog abort, then a run that clears the flag
        cap_cnt   = 0;
        done_cnt  = 0;
        exp_q.delete();
        valid_all = 1'b0;
        num_iter  = 5'd3;
        start     = 1'b1;
        step();
        start     = 1'b0;
        wait_done(200, cyc);
        chk("timeout_latency", 128'(cyc >= 65 && cyc <= 67), 128'(1));
        chk("timeout_flag", 128'(timeout), 128'(1));
        chk("timeout_no_cap", 128'(cap_cnt), 128'(0));
        run_full(2, 1'b0, -1);

        // Rejected writes: while busy (with an ignored start) and out of range
        run_full(3, 1'b0, 1);
        wr(DEPTH, {$urandom, $urandom, $urandom, $urandom});
        wr(DEPTH + 3, {$urandom, $urandom, $urandom, $urandom});
        run_full(3, 1'b0, -1);

        // Randomized loads and run lengths, including the clip above DEPTH
        for (int r = 0; r < 6; r++) begin
            repeat (3) wr(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom, $urandom, $urandom});
            run_full(int'($urandom_range(1, DEPTH)), 1'(r % 2), -1);
        end
        run_full(DEPTH, 1'b0, -1);
        run_full(16, 1'b0, -1);

        // Async reset while draining sample 1
        start_run(3, 1'b0);
        pulse(0, W'($urandom), W'($urandom), 2);
        pulse(1, W'($urandom), W'($urandom), 2);
        valid_all = 1'b1;
        #2;
        rst_n_btn = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        valid_all = 1'b0;
        exp_q.delete();
        in_run    = 1'b0;
        repeat (3) step();
        rst_n_btn = 1'b1;
        step();
        chk("post_reset_idle", 128'(busy), 128'(0));
        run_full(2, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
